// File: rtl/array_0_6_ctrl.sv
// array_0_6_ctrl: 1RW SRAM access controller with read/write round-robin and response FIFO.
// Optional init sweep: define ARRAY_0_6_CTRL_INIT_EN.
module array_0_6_ctrl #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int RESP_DEPTH = 4,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_req_addr,
  output logic              rd_resp_valid,
  input  logic              rd_resp_ready,
  output logic [DATA_W-1:0] rd_resp_data,
  input  logic              wr_req_valid,
  output logic              wr_req_ready,
  input  logic [ADDR_W-1:0] wr_req_addr,
  input  logic [DATA_W-1:0] wr_req_data,
  output logic              init_done,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int NW = $clog2(RESP_DEPTH + 1);
  localparam int CW = $clog2(RESP_DEPTH + 3) + 1;

  logic              run;
  logic              last_wr;
  logic              rd_fire;
  logic              wr_fire;
  logic              has_credit;
  logic [CW-1:0]     used;

  logic              p1;
  logic              p2;
  logic [NW-1:0]     count;
  logic [PW-1:0]     wp;
  logic [PW-1:0]     rp;
  logic [DATA_W-1:0] mem [RESP_DEPTH];
  logic              push;
  logic              pop;

`ifdef ARRAY_0_6_CTRL_INIT_EN
  typedef enum logic {S_INIT, S_RUN} state_t;
  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              swept;
  assign run = (state == S_RUN);
`else
  logic run_q;
  logic unused_init;
  assign run = run_q;
  assign init_done = 1'b1;
  assign unused_init = ^INIT_VALUE;
`endif

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credits: FIFO slots not yet claimed by stored or in-flight reads.
  always_comb begin
    used = CW'(count) + CW'(p1) + CW'(p2);
    has_credit = (used < CW'(RESP_DEPTH));
    rd_req_ready = run & has_credit & (~wr_req_valid | last_wr);
    wr_req_ready = run & (~rd_req_valid | ~last_wr | ~has_credit);
    rd_fire = rd_req_valid & rd_req_ready;
    wr_fire = wr_req_valid & wr_req_ready;
    push = p2;
    pop = rd_resp_valid & rd_resp_ready;
  end

  assign rd_resp_valid = (count != '0);
  assign rd_resp_data = mem[rp];

  // Control FSM: init sweep, then arbitrated access onto the RW port.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sram_en <= 1'b0;
      sram_wmode <= 1'b0;
      sram_addr <= '0;
      sram_wdata <= '0;
      last_wr <= 1'b1;
`ifdef ARRAY_0_6_CTRL_INIT_EN
      state <= S_INIT;
      cnt <= '0;
      swept <= 1'b0;
      init_done <= 1'b0;
`else
      run_q <= 1'b0;
`endif
    end else begin
`ifdef ARRAY_0_6_CTRL_INIT_EN
      if (state == S_INIT) begin
        if (swept) begin
          sram_en <= 1'b0;
          sram_wmode <= 1'b0;
          state <= S_RUN;
          init_done <= 1'b1;
        end else begin
          sram_en <= 1'b1;
          sram_wmode <= 1'b1;
          sram_addr <= cnt;
          sram_wdata <= INIT_VALUE;
          cnt <= cnt + ADDR_W'(1);
          swept <= (cnt == {ADDR_W{1'b1}});
        end
      end else begin
`else
      begin
        run_q <= 1'b1;
`endif
        unique case (1'b1)
          rd_fire: begin
            sram_en <= 1'b1;
            sram_wmode <= 1'b0;
            sram_addr <= rd_req_addr;
            last_wr <= 1'b0;
          end
          wr_fire: begin
            sram_en <= 1'b1;
            sram_wmode <= 1'b1;
            sram_addr <= wr_req_addr;
            sram_wdata <= wr_req_data;
            last_wr <= 1'b1;
          end
          default: begin
            sram_en <= 1'b0;
          end
        endcase
      end
    end
  end

  // Read tracking and response FIFO; capture lands two cycles after accept.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      p1 <= 1'b0;
      p2 <= 1'b0;
      count <= '0;
      wp <= '0;
      rp <= '0;
      for (int i = 0; i < RESP_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      p1 <= rd_fire;
      p2 <= p1;
      if (push) begin
        mem[wp] <= sram_rdata;
        wp <= nxt(wp);
      end
      if (pop) begin
        rp <= nxt(rp);
      end
      if (push && !pop) begin
        count <= count + NW'(1);
      end else if (!push && pop) begin
        count <= count - NW'(1);
      end
    end
  end

endmodule

// File: tb/tb_array_0_6_ctrl.sv
// tb_array_0_6_ctrl: scoreboard bench for array_0_6_ctrl.
// Runs with or without ARRAY_0_6_CTRL_INIT_EN.
module tb_array_0_6_ctrl;

  localparam int AW = 14;
  localparam int DW = 32;
  localparam int RD = 4;
  localparam logic [DW-1:0] IV = 32'h0;
`ifdef ARRAY_0_6_CTRL_INIT_EN
  localparam logic INIT_RST = 1'b0;
`else
  localparam logic INIT_RST = 1'b1;
`endif

  logic          clock;
  logic          reset_n;
  logic          rd_req_valid;
  logic          rd_req_ready;
  logic [AW-1:0] rd_req_addr;
  logic          rd_resp_valid;
  logic          rd_resp_ready;
  logic [DW-1:0] rd_resp_data;
  logic          wr_req_valid;
  logic          wr_req_ready;
  logic [AW-1:0] wr_req_addr;
  logic [DW-1:0] wr_req_data;
  logic          init_done;
  logic [AW-1:0] sram_addr;
  logic          sram_en;
  logic          sram_wmode;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;

  array_0_6_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .RESP_DEPTH(RD), .INIT_VALUE(IV)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_req_addr(rd_req_addr),
    .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready),
    .rd_resp_data(rd_resp_data),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
    .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
    .init_done(init_done),
    .sram_addr(sram_addr), .sram_en(sram_en),
    .sram_wmode(sram_wmode), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [DW-1:0] smem [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] sb [$];
  int n_chk;
  int n_pass;

  // SRAM array model: read data one cycle after enable.
  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) smem[sram_addr] <= sram_wdata;
      else sram_rdata <= smem[sram_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // Scoreboard: expected data pushed at read accept, compared at pop.
  always @(negedge clock) begin
    if (reset_n) begin
      if (rd_resp_valid && rd_resp_ready) begin
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else chk("rdata", rd_resp_data, sb.pop_front());
      end
      if (rd_req_valid && rd_req_ready && wr_req_valid && wr_req_ready)
        chk("one_grant", 1, 0);
      if (rd_req_valid && rd_req_ready)
        sb.push_back(ref_mem[rd_req_addr]);
      if (wr_req_valid && wr_req_ready)
        ref_mem[wr_req_addr] = wr_req_data;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic ref_fill();
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = IV;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rrdy"}, rd_req_ready, 0);
    chk({tag, "_wrdy"}, wr_req_ready, 0);
    chk({tag, "_rvld"}, rd_resp_valid, 0);
    chk({tag, "_rdata"}, rd_resp_data, 0);
    chk({tag, "_en"}, sram_en, 0);
    chk({tag, "_wmode"}, sram_wmode, 0);
    chk({tag, "_addr"}, sram_addr, 0);
    chk({tag, "_wdata"}, sram_wdata, 0);
    chk({tag, "_idone"}, init_done, INIT_RST);
  endtask

  task automatic do_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_req_valid = 1'b1;
    wr_req_addr = a;
    wr_req_data = d;
    @(negedge clock);
    chk("wr_rdy", wr_req_ready, 1);
    step();
    wr_req_valid = 1'b0;
  endtask

  task automatic do_rd(input logic [AW-1:0] a);
    rd_req_valid = 1'b1;
    rd_req_addr = a;
    @(negedge clock);
    chk("rd_rdy", rd_req_ready, 1);
    step();
    rd_req_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 50) begin
      step();
      k++;
    end
    chk(tag, sb.size(), 0);
  endtask

  // Wait for the post-reset sweep (if any) and check it.
  task automatic come_up(input bit full);
    int bad;
    bad = 0;
`ifdef ARRAY_0_6_CTRL_INIT_EN
    for (int i = 0; i < (1 << AW); i++) begin
      step();
      @(negedge clock);
      if (!sram_en || !sram_wmode || sram_addr != AW'(i) ||
          sram_wdata != IV || rd_req_ready || wr_req_ready || init_done)
        bad++;
      if (rd_resp_valid) bad++;
      if (i == 0) chk("sweep_addr0", sram_addr, 0);
    end
    if (full) chk("init_sweep", bad, 0);
    step();
    @(negedge clock);
    chk("init_done", init_done, 1);
    chk("init_en_off", sram_en, 0);
`else
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clock);
      if (rd_resp_valid || sram_en) bad++;
    end
    if (full) chk("idle_after_rst", bad, 0);
    chk("init_done", init_done, 1);
`endif
    chk("no_stale", bad, 0);
    step();
  endtask

  initial begin
    int ri;
    int wi;
    int acc;
    int pops;
    int newacc;
    logic [5:0] gseq;
    logic [5:0] mseq;
    logic [5:0] eseq;
    int idle;

    n_chk = 0;
    n_pass = 0;
    rd_req_valid = 1'b0;
    rd_req_addr = '0;
    wr_req_valid = 1'b0;
    wr_req_addr = '0;
    wr_req_data = '0;
    rd_resp_ready = 1'b1;
    ref_fill();
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    @(negedge clock);
    chk_reset_vals("rst");
    @(posedge clock);
    #1 reset_n = 1'b1;
    come_up(1'b1);

`ifdef ARRAY_0_6_CTRL_INIT_EN
    do_rd(AW'(7));
    drain("init_read_drain");
`endif

    for (int i = 0; i < 4; i++)
      do_wr(AW'(32'h200 + i), 32'hA5A50000 + i);

    // Both requesters valid: grants must alternate, read first.
    rd_req_valid = 1'b1;
    wr_req_valid = 1'b1;
    ri = 0;
    wi = 0;
    idle = 0;
    gseq = '0;
    mseq = '0;
    eseq = '0;
    for (int c = 0; c < 6; c++) begin
      rd_req_addr = AW'(32'h200 + ri);
      wr_req_addr = AW'(32'h300 + wi);
      wr_req_data = 32'hC0DE0000 + wi;
      @(negedge clock);
      if (c > 0) begin
        mseq[c-1] = sram_wmode;
        eseq[c-1] = sram_en;
      end
      if (rd_req_ready) ri++;
      else if (wr_req_ready) begin
        wi++;
        gseq[c] = 1'b1;
      end else idle++;
      step();
    end
    rd_req_valid = 1'b0;
    wr_req_valid = 1'b0;
    @(negedge clock);
    mseq[5] = sram_wmode;
    eseq[5] = sram_en;
    chk("conflict_grant", gseq, 6'b101010);
    chk("conflict_idle", idle, 0);
    chk("conflict_wmode", mseq, 6'b101010);
    chk("conflict_en", eseq, 6'h3f);
    step();
    drain("conflict_drain");

    // Read-after-write on consecutive cycles.
    wr_req_valid = 1'b1;
    wr_req_addr = AW'(32'h1234);
    wr_req_data = 32'hDEADBEEF;
    @(negedge clock);
    chk("raw_wrdy", wr_req_ready, 1);
    step();
    wr_req_valid = 1'b0;
    rd_req_valid = 1'b1;
    rd_req_addr = AW'(32'h1234);
    @(negedge clock);
    chk("raw_rrdy", rd_req_ready, 1);
    chk("raw_wr_pins", {sram_en, sram_wmode, 18'(sram_addr), sram_wdata},
        {1'b1, 1'b1, 18'h1234, 32'hDEADBEEF});
    step();
    rd_req_valid = 1'b0;
    @(negedge clock);
    chk("raw_rd_pins", {sram_en, sram_wmode, 18'(sram_addr)},
        {1'b1, 1'b0, 18'h1234});
    chk("raw_vld_n2", rd_resp_valid, 0);
    step();
    @(negedge clock);
    chk("raw_vld_n3", rd_resp_valid, 0);
    step();
    @(negedge clock);
    chk("raw_vld_n4", rd_resp_valid, 1);
    chk("raw_data", rd_resp_data, 32'hDEADBEEF);
    step();
    drain("raw_drain");

    // Backpressure: only RESP_DEPTH reads fit.
    rd_resp_ready = 1'b0;
    rd_req_valid = 1'b1;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      rd_req_addr = AW'(32'h200 + (acc % 4));
      @(negedge clock);
      if (rd_req_ready) acc++;
      step();
    end
    @(negedge clock);
    chk("bp_accepts", acc, RD);
    chk("bp_rrdy_low", rd_req_ready, 0);
    chk("bp_resp_vld", rd_resp_valid, 1);
    step();
    rd_resp_ready = 1'b1;
    pops = 0;
    newacc = 0;
    for (int c = 0; c < 10; c++) begin
      rd_req_addr = AW'(32'h200 + (newacc % 4));
      @(negedge clock);
      if (rd_resp_valid) pops++;
      if (rd_req_ready) newacc++;
      step();
    end
    rd_req_valid = 1'b0;
    chk("bp_drained", pops >= RD, 1);
    chk("bp_resumed", newacc > 0, 1);
    drain("bp_drain");

    // Reset with two reads in flight and two in the FIFO.
    rd_resp_ready = 1'b0;
    rd_req_valid = 1'b1;
    acc = 0;
    for (int c = 0; c < 4; c++) begin
      rd_req_addr = AW'(32'h200 + c);
      @(negedge clock);
      if (rd_req_ready) acc++;
      step();
    end
    rd_req_valid = 1'b0;
    chk("mid_accepts", acc, 4);
    #2 reset_n = 1'b0;
    sb.delete();
    #1;
    chk_reset_vals("mid_rst");
`ifdef ARRAY_0_6_CTRL_INIT_EN
    ref_fill();
`endif
    rd_resp_ready = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1 reset_n = 1'b1;
    come_up(1'b0);

    // Array still usable after reset.
    do_rd(AW'(32'h1234));
    drain("final_drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
